// File: rtl/axi4_lite_pkg.sv
// Shared types and the address-window decode used by the AXI4-Lite slave bridge.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_COLLECT = 2'd1,
    W_ISSUE   = 2'd2,
    W_RESP    = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  // Operands are widened to 64 bits so one function serves any bus width.
  function automatic logic addr_hit(input logic [63:0] addr,
                                    input logic [63:0] base,
                                    input logic [63:0] span);
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

endinterface

// File: rtl/axi4_lite_rd_channel.sv
// Read side of the bridge: AR decode, peripheral read request with timeout, R response.
module axi4_lite_rd_channel
  import axi4_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN  = ADDR_WIDTH'(32'h0000_1000),
  parameter int                    RD_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel_i,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic                  read_req_o,
  output logic [ADDR_WIDTH-1:0] read_addr_o,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  input  logic                  data_valid_i
);

  localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  rd_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  resp_t                 rresp_q, rresp_d;
  logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
  logic                  ar_hs;

  assign arready_o   = rst && sel_i && (state_q == R_IDLE);
  assign ar_hs       = arready_o && arvalid_i;
  assign rvalid_o    = (state_q == R_RESP);
  assign read_req_o  = (state_q == R_WAIT);
  assign rdata_o     = rdata_q;
  assign rresp_o     = rresp_q;
  assign read_addr_o = read_addr_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    read_addr_d = read_addr_q;
    case (state_q)
      R_IDLE: begin
        if (ar_hs) begin
          read_addr_d = araddr_i - BASE_ADDR;
          if (addr_hit(64'(araddr_i), 64'(BASE_ADDR), 64'(ADDR_SPAN))) begin
            state_d = R_WAIT;
            cnt_d   = '0;
          end else begin
            state_d = R_RESP;
            rdata_d = '0;
            rresp_d = DECERR;
          end
        end
      end
      R_WAIT: begin
        // Data arriving on the final allowed cycle still beats the timeout.
        if (data_valid_i) begin
          state_d = R_RESP;
          rdata_d = read_data_i;
          rresp_d = OKAY;
        end else if (cnt_q == CNT_LAST) begin
          state_d = R_RESP;
          rdata_d = '0;
          rresp_d = SLVERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      R_RESP: begin
        if (rready_i) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= R_IDLE;
      cnt_q       <= '0;
      rdata_q     <= '0;
      rresp_q     <= OKAY;
      read_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      read_addr_q <= read_addr_d;
    end
  end

endmodule

// File: rtl/axi4_lite_slave_bridge.sv
// AXI4-Lite slave endpoint driving a native peripheral write/read port.
module axi4_lite_slave_bridge
  import axi4_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN  = ADDR_WIDTH'(32'h0000_1000),
  parameter int                    RD_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  slave_write_sel,
  input  logic                  slave_read_sel,
  output logic                  mem_write,
  output logic [STRB_WIDTH-1:0] byte_en,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_ready,
  output logic                  read_req,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  data_valid,
  axi4_lite_if.slave            slave_if
);

  wr_state_t             wr_state_q, wr_state_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  aw_hit_q, aw_hit_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic [STRB_WIDTH-1:0] byte_en_q, byte_en_d;
  resp_t                 bresp_q, bresp_d;

  logic accepting, aw_ready, w_ready, aw_hs, w_hs, aw_have, w_have;

  assign accepting = rst && slave_write_sel &&
                     ((wr_state_q == W_IDLE) || (wr_state_q == W_COLLECT));
  assign aw_ready  = accepting && !aw_done_q;
  assign w_ready   = accepting && !w_done_q;
  assign aw_hs     = aw_ready && slave_if.awvalid;
  assign w_hs      = w_ready && slave_if.wvalid;
  assign aw_have   = aw_done_q || aw_hs;
  assign w_have    = w_done_q || w_hs;

  assign slave_if.awready = aw_ready;
  assign slave_if.wready  = w_ready;
  assign slave_if.bvalid  = (wr_state_q == W_RESP);
  assign slave_if.bresp   = bresp_q;
  assign mem_write        = (wr_state_q == W_ISSUE);
  assign write_addr       = write_addr_q;
  assign write_data       = write_data_q;
  assign byte_en          = byte_en_q;

  always_comb begin
    wr_state_d   = wr_state_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    aw_hit_d     = aw_hit_q;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    byte_en_d    = byte_en_q;
    bresp_d      = bresp_q;
    if (aw_hs) begin
      write_addr_d = slave_if.awaddr - BASE_ADDR;
      aw_hit_d     = addr_hit(64'(slave_if.awaddr), 64'(BASE_ADDR), 64'(ADDR_SPAN));
    end
    if (w_hs) begin
      write_data_d = slave_if.wdata;
      byte_en_d    = slave_if.wstrb;
    end
    case (wr_state_q)
      W_IDLE, W_COLLECT: begin
        // The _d copies already merge this cycle's handshake with earlier captures.
        if (aw_have && w_have) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (!aw_hit_d) begin
            wr_state_d = W_RESP;
            bresp_d    = DECERR;
          end else if (byte_en_d == '0) begin
            wr_state_d = W_RESP;
            bresp_d    = OKAY;
          end else begin
            wr_state_d = W_ISSUE;
          end
        end else if (aw_have || w_have) begin
          aw_done_d  = aw_have;
          w_done_d   = w_have;
          wr_state_d = W_COLLECT;
        end
      end
      W_ISSUE: begin
        if (write_ready) begin
          wr_state_d = W_RESP;
          bresp_d    = OKAY;
        end
      end
      W_RESP: begin
        if (slave_if.bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_state_q   <= W_IDLE;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      aw_hit_q     <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      byte_en_q    <= '0;
      bresp_q      <= OKAY;
    end else begin
      wr_state_q   <= wr_state_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      aw_hit_q     <= aw_hit_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      byte_en_q    <= byte_en_d;
      bresp_q      <= bresp_d;
    end
  end

  axi4_lite_rd_channel #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .ADDR_SPAN  (ADDR_SPAN),
    .RD_TIMEOUT (RD_TIMEOUT)
  ) u_rd_channel (
    .clk          (clk),
    .rst          (rst),
    .sel_i        (slave_read_sel),
    .araddr_i     (slave_if.araddr),
    .arvalid_i    (slave_if.arvalid),
    .arready_o    (slave_if.arready),
    .rdata_o      (slave_if.rdata),
    .rresp_o      (slave_if.rresp),
    .rvalid_o     (slave_if.rvalid),
    .rready_i     (slave_if.rready),
    .read_req_o   (read_req),
    .read_addr_o  (read_addr),
    .read_data_i  (read_data),
    .data_valid_i (data_valid)
  );

endmodule

// File: tb/tb_axi4_lite_slave_bridge.sv
// Directed self-checking bench for axi4_lite_slave_bridge (RD_TIMEOUT = 8).
module tb_axi4_lite_slave_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          slave_write_sel, slave_read_sel;
  logic          mem_write, write_ready, read_req, data_valid;
  logic [SW-1:0] byte_en;
  logic [AW-1:0] write_addr, read_addr;
  logic [DW-1:0] write_data, read_data;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  axi4_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_slave_bridge #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RD_TIMEOUT (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .slave_write_sel (slave_write_sel),
    .slave_read_sel  (slave_read_sel),
    .mem_write       (mem_write),
    .byte_en         (byte_en),
    .write_addr      (write_addr),
    .write_data      (write_data),
    .write_ready     (write_ready),
    .read_req        (read_req),
    .read_addr       (read_addr),
    .read_data       (read_data),
    .data_valid      (data_valid),
    .slave_if        (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    slave_write_sel = 0; slave_read_sel = 0; write_ready = 0; data_valid = 0; read_data = '0;
    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
    bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;

    // Reset state
    repeat (3) nxt();
    rst = 1;
    smp();
    check("rst_mem_write", mem_write, 0);
    check("rst_read_req", read_req, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_awready", bus.awready, 0);
    check("rst_arready", bus.arready, 0);
    check("rst_outputs", {byte_en, write_addr, write_data, read_addr}, 0);
    check("rst_rdata", bus.rdata, 0);
    nxt();

    // Same-cycle AW+W, write_ready tied high
    slave_write_sel = 1; slave_read_sel = 1; write_ready = 1;
    bus.awvalid = 1; bus.awaddr = 32'h10; bus.wvalid = 1; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
    smp();
    check("t1_awready", bus.awready, 1);
    check("t1_wready", bus.wready, 1);
    nxt();
    bus.awvalid = 0; bus.wvalid = 0;
    smp();
    check("t1_mem_write_k1", mem_write, 1);
    check("t1_write_addr", write_addr, 32'h10);
    check("t1_write_data", write_data, 32'hDEADBEEF);
    check("t1_byte_en", byte_en, 4'hF);
    check("t1_bvalid_k1", bus.bvalid, 0);
    nxt();
    smp();
    check("t1_mem_write_k2", mem_write, 0);
    check("t1_bvalid_k2", bus.bvalid, 1);
    check("t1_bresp", bus.bresp, 2'b00);
    bus.bready = 1;
    nxt();
    bus.bready = 0;
    smp();
    check("t1_bvalid_done", bus.bvalid, 0);
    nxt();

    // W three cycles ahead of AW, write_ready delayed
    write_ready = 0;
    bus.wvalid = 1; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'h3;
    smp();
    check("t2_wready", bus.wready, 1);
    nxt();
    bus.wvalid = 0;
    smp();
    check("t2_wready_held", bus.wready, 0);
    check("t2_awready_open", bus.awready, 1);
    nxt();
    nxt();
    bus.awvalid = 1; bus.awaddr = 32'h20;
    smp();
    check("t2_awready", bus.awready, 1);
    nxt();
    bus.awvalid = 0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      write_ready = (i == 4);
      smp();
      if (bus.bvalid) break;
      if (mem_write) n++;
      if (i == 0) begin
        check("t2_write_addr", write_addr, 32'h20);
        check("t2_write_data", write_data, 32'hCAFEF00D);
        check("t2_byte_en", byte_en, 4'h3);
      end
      nxt();
    end
    write_ready = 0;
    check("t2_mem_write_cycles", n, 5);
    check("t2_mem_write_low", mem_write, 0);
    check("t2_bvalid", bus.bvalid, 1);
    check("t2_bresp", bus.bresp, 2'b00);
    bus.bready = 1;
    nxt();
    bus.bready = 0;

    // Out-of-window write -> DECERR
    write_ready = 1;
    bus.awvalid = 1; bus.awaddr = 32'h2000; bus.wvalid = 1; bus.wdata = 32'h1; bus.wstrb = 4'hF;
    nxt();
    bus.awvalid = 0; bus.wvalid = 0;
    smp();
    check("t3_miss_mem_write", mem_write, 0);
    check("t3_miss_bvalid", bus.bvalid, 1);
    check("t3_miss_bresp", bus.bresp, 2'b11);
    bus.bready = 1;
    nxt();
    bus.bready = 0;

    // Zero strobe -> OKAY without a peripheral write
    bus.awvalid = 1; bus.awaddr = 32'h30; bus.wvalid = 1; bus.wstrb = 4'h0;
    nxt();
    bus.awvalid = 0; bus.wvalid = 0;
    smp();
    check("t3_strb0_mem_write", mem_write, 0);
    check("t3_strb0_bvalid", bus.bvalid, 1);
    check("t3_strb0_bresp", bus.bresp, 2'b00);
    bus.bready = 1;
    nxt();
    bus.bready = 0;
    write_ready = 0;

    // Out-of-window read -> DECERR
    bus.arvalid = 1; bus.araddr = 32'h2000; read_data = 32'hFFFFFFFF;
    smp();
    check("t3_arready", bus.arready, 1);
    nxt();
    bus.arvalid = 0;
    smp();
    check("t3_miss_read_req", read_req, 0);
    check("t3_miss_rvalid", bus.rvalid, 1);
    check("t3_miss_rresp", bus.rresp, 2'b11);
    check("t3_miss_rdata", bus.rdata, 0);
    bus.rready = 1;
    nxt();
    bus.rready = 0;
    smp();
    check("t3_rvalid_done", bus.rvalid, 0);
    nxt();

    // Read with data after two cycles, RREADY held low
    bus.arvalid = 1; bus.araddr = 32'h40;
    nxt();
    bus.arvalid = 0;
    smp();
    check("t4_read_req", read_req, 1);
    check("t4_read_addr", read_addr, 32'h40);
    check("t4_rvalid_early", bus.rvalid, 0);
    nxt();
    data_valid = 1; read_data = 32'h12345678;
    nxt();
    data_valid = 0; read_data = 32'hFFFFFFFF;
    for (int j = 0; j < 3; j++) begin
      smp();
      check("t4_rvalid_hold", bus.rvalid, 1);
      check("t4_rdata_hold", bus.rdata, 32'h12345678);
      check("t4_rresp", bus.rresp, 2'b00);
      nxt();
    end
    bus.rready = 1;
    nxt();
    bus.rready = 0;
    smp();
    check("t4_rvalid_done", bus.rvalid, 0);
    nxt();

    // Timeout with no data -> SLVERR after 8 request cycles
    read_data = 32'hAAAA5555;
    bus.arvalid = 1; bus.araddr = 32'h80;
    nxt();
    bus.arvalid = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      smp();
      if (bus.rvalid) break;
      if (read_req) n++;
      nxt();
    end
    check("t5_req_cycles", n, 8);
    check("t5_rvalid", bus.rvalid, 1);
    check("t5_rresp", bus.rresp, 2'b10);
    check("t5_rdata", bus.rdata, 0);
    bus.rready = 1;
    nxt();
    bus.rready = 0;

    // Data on the final cycle wins over the timeout
    bus.arvalid = 1; bus.araddr = 32'h84; read_data = 32'h0BADC0DE;
    nxt();
    bus.arvalid = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      data_valid = (i == 7);
      smp();
      if (bus.rvalid) break;
      if (read_req) n++;
      nxt();
    end
    data_valid = 0;
    check("t5b_req_cycles", n, 8);
    check("t5b_rvalid", bus.rvalid, 1);
    check("t5b_rresp", bus.rresp, 2'b00);
    check("t5b_rdata", bus.rdata, 32'h0BADC0DE);
    bus.rready = 1;
    nxt();
    bus.rready = 0;

    // Reset in the middle of concurrent transactions
    bus.awvalid = 1; bus.awaddr = 32'h50; bus.wvalid = 1; bus.wdata = 32'h55; bus.wstrb = 4'hF;
    bus.arvalid = 1; bus.araddr = 32'h60;
    nxt();
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    smp();
    check("t6_mem_write_pre", mem_write, 1);
    check("t6_read_req_pre", read_req, 1);
    nxt();
    rst = 0; slave_write_sel = 0; slave_read_sel = 0;
    nxt();
    rst = 1;
    smp();
    check("t6_mem_write", mem_write, 0);
    check("t6_read_req", read_req, 0);
    check("t6_outputs", {byte_en, write_addr, write_data, read_addr}, 0);
    check("t6_resp", {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp}, 0);
    check("t6_rdata", bus.rdata, 0);
    write_ready = 1; data_valid = 1;
    for (int j = 0; j < 3; j++) begin
      nxt();
      smp();
      check("t6_no_response", {bus.bvalid, bus.rvalid}, 0);
    end
    write_ready = 0; data_valid = 0;
    nxt();

    // Normal concurrent write and read after reset
    slave_write_sel = 1; slave_read_sel = 1; write_ready = 1;
    bus.awvalid = 1; bus.awaddr = 32'h04; bus.wvalid = 1; bus.wdata = 32'h11223344; bus.wstrb = 4'hC;
    bus.arvalid = 1; bus.araddr = 32'h08;
    nxt();
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    smp();
    check("t6n_mem_write", mem_write, 1);
    check("t6n_write_addr", write_addr, 32'h04);
    check("t6n_byte_en", byte_en, 4'hC);
    check("t6n_read_req", read_req, 1);
    check("t6n_read_addr", read_addr, 32'h08);
    data_valid = 1; read_data = 32'h99887766;
    nxt();
    data_valid = 0;
    smp();
    check("t6n_bvalid", bus.bvalid, 1);
    check("t6n_bresp", bus.bresp, 2'b00);
    check("t6n_rvalid", bus.rvalid, 1);
    check("t6n_rdata", bus.rdata, 32'h99887766);
    check("t6n_rresp", bus.rresp, 2'b00);
    bus.bready = 1; bus.rready = 1;
    nxt();
    bus.bready = 0; bus.rready = 0;
    smp();
    check("t6n_done", {bus.bvalid, bus.rvalid}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
